// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and counter arithmetic for the PHT controller
package bpu_pkg;

  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t SNT = 2'd0;
  localparam pht_ctr_t WNT = 2'd1;
  localparam pht_ctr_t WT  = 2'd2;
  localparam pht_ctr_t ST  = 2'd3;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } pht_state_e;

  function automatic pht_ctr_t sat_update(pht_ctr_t c, logic taken);
    if (taken) begin
      return (c == ST) ? ST : pht_ctr_t'(c + 2'd1);
    end
    return (c == SNT) ? SNT : pht_ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bpu_upd_fifo.sv
// rtl/bpu_upd_fifo.sv - synchronous update FIFO; a push into a full FIFO is accepted only alongside a pop
module bpu_upd_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  entry_t                  wdata,
  output entry_t                  rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/bpu_pht_ctrl.sv
// rtl/bpu_pht_ctrl.sv - PHT port sequencer: post-reset clear sweep, lookup/update arbitration, starvation guard
module bpu_pht_ctrl
  import bpu_pkg::*;
#(
  parameter int IDX_W      = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         lookup_valid,
  input  logic [IDX_W-1:0]             lookup_idx,
  input  logic                         upd_valid,
  input  logic [IDX_W-1:0]             upd_idx,
  input  logic                         upd_taken,
  output logic [IDX_W-1:0]             pht_addr,
  output logic                         pht_we,
  output logic [1:0]                   pht_wdata,
  input  logic [1:0]                   pht_rdata,
  output logic                         BP,
  output logic                         bp_valid,
  output logic                         init_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_entry_t;

  pht_state_e        state_q, state_d;
  logic [IDX_W-1:0]  sweep_q, sweep_d;
  logic [ST_W-1:0]   starve_q, starve_d;

  upd_entry_t        push_ent, head_ent;
  logic              fifo_push, fifo_full, fifo_empty;
  logic              upd_grant, force_upd;

  assign push_ent  = '{idx: upd_idx, taken: upd_taken};
  assign fifo_push = upd_valid && (state_q == S_RUN);
  assign init_done = (state_q == S_RUN);

  bpu_upd_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (upd_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (upd_grant),
    .wdata (push_ent),
    .rdata (head_ent),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    starve_d  = starve_q;
    pht_addr  = lookup_idx;
    pht_we    = 1'b0;
    pht_wdata = SNT;
    BP        = 1'b0;
    bp_valid  = 1'b0;
    upd_grant = 1'b0;
    force_upd = fifo_full || (starve_q == ST_W'(STARVE_MAX));

    case (state_q)
      S_INIT: begin
        pht_addr  = sweep_q;
        pht_we    = 1'b1;
        pht_wdata = WNT;
        sweep_d   = sweep_q + IDX_W'(1);
        if (sweep_q == {IDX_W{1'b1}}) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Update slot wins whenever fetch is quiet or the queue must make progress.
        if (!fifo_empty && (force_upd || !lookup_valid)) begin
          upd_grant = 1'b1;
          pht_addr  = head_ent.idx;
          pht_we    = 1'b1;
          pht_wdata = sat_update(pht_rdata, head_ent.taken);
        end else if (lookup_valid) begin
          bp_valid = 1'b1;
          BP       = pht_rdata[1];
        end

        if (fifo_empty || upd_grant) begin
          starve_d = '0;
        end else if (lookup_valid && (starve_q != ST_W'(STARVE_MAX))) begin
          starve_d = starve_q + ST_W'(1);
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_INIT;
      sweep_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_bpu_pht_ctrl.sv
// tb/tb_bpu_pht_ctrl.sv - self-checking bench for bpu_pht_ctrl with a queue-based reference model
module tb_bpu_pht_ctrl;

  localparam int IDX_W = 3;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
  localparam int NENT  = 1 << IDX_W;

  logic             clk, reset;
  logic             lookup_valid, upd_valid, upd_taken;
  logic [IDX_W-1:0] lookup_idx, upd_idx, pht_addr;
  logic             pht_we, BP, bp_valid, init_done;
  logic [1:0]       pht_wdata, pht_rdata;
  logic [2:0]       fifo_count;

  logic [1:0] ram [NENT];

  bpu_pht_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_taken    (upd_taken),
    .pht_addr     (pht_addr),
    .pht_we       (pht_we),
    .pht_wdata    (pht_wdata),
    .pht_rdata    (pht_rdata),
    .BP           (BP),
    .bp_valid     (bp_valid),
    .init_done    (init_done),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pht_rdata = ram[pht_addr];
  always @(posedge clk) if (pht_we) ram[pht_addr] <= pht_wdata;

  int vectors = 0;
  int errors  = 0;

  typedef struct { int idx; int tk; } ent_t;
  ent_t q[$];
  int   mram [NENT];
  int   starve;
  bit   m_init;
  int   sweep;
  int   s_we, s_wd, s_bp, s_bpv, s_cnt;

  typedef struct {
    bit lv; int li; bit uv; int ui; bit ut;
    int e_we; int e_wd; int e_bp; int e_bpv; int e_cnt;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_init = 1'b1;
    sweep  = 0;
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, advance the model at the rising edge.
  task automatic step(input bit lv, input int li, input bit uv, input int ui, input bit ut);
    int e_addr, e_we, e_wd, e_bp, e_bpv, c;
    bit ug, lg;
    lookup_valid = lv;
    lookup_idx   = IDX_W'(li);
    upd_valid    = uv;
    upd_idx      = IDX_W'(ui);
    upd_taken    = ut;
    #1;
    ug = 1'b0; lg = 1'b0; e_wd = 0; e_bp = 0; e_bpv = 0;
    if (m_init) begin
      e_addr = sweep; e_we = 1; e_wd = 1;
    end else begin
      e_addr = li; e_we = 0;
      if (q.size() > 0 && (q.size() == DEPTH || starve == SMAX || !lv)) begin
        ug = 1'b1;
        e_addr = q[0].idx;
        e_we = 1;
        c = mram[q[0].idx];
        e_wd = q[0].tk ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
      end else if (lv) begin
        lg = 1'b1;
        e_bpv = 1;
        e_bp = mram[li] / 2;
      end
    end
    chk("pht_addr", int'(pht_addr), e_addr);
    chk("pht_we", int'(pht_we), e_we);
    if (e_we != 0) chk("pht_wdata", int'(pht_wdata), e_wd);
    chk("BP", int'(BP), e_bp);
    chk("bp_valid", int'(bp_valid), e_bpv);
    chk("init_done", int'(init_done), m_init ? 0 : 1);
    chk("fifo_count", int'(fifo_count), q.size());
    s_we = int'(pht_we); s_wd = int'(pht_wdata); s_bp = int'(BP);
    s_bpv = int'(bp_valid); s_cnt = int'(fifo_count);
    @(posedge clk);
    if (m_init) begin
      mram[sweep] = 1;
      sweep++;
      if (sweep == NENT) m_init = 1'b0;
    end else begin
      if (ug) begin
        mram[q[0].idx] = e_wd;
        void'(q.pop_front());
        starve = 0;
      end else if (q.size() == 0) begin
        starve = 0;
      end else if (lg && starve < SMAX) begin
        starve++;
      end
      if (uv) q.push_back('{ui, int'(ut)});
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, int'(pht_we), 1);
    chk({tag, "_addr"}, int'(pht_addr), 0);
    chk({tag, "_wdata"}, int'(pht_wdata), 1);
    chk({tag, "_bpv"}, int'(bp_valid), 0);
    chk({tag, "_bp"}, int'(BP), 0);
    chk({tag, "_init"}, int'(init_done), 0);
    chk({tag, "_cnt"}, int'(fifo_count), 0);
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < NENT; i++) chk($sformatf("%s_ram%0d", tag, i), int'(ram[i]), mram[i]);
  endtask

  initial begin
    tbl[0]  = '{0,0, 1,5,1,  0,0,0,0,0};
    tbl[1]  = '{0,0, 0,0,0,  1,2,0,0,1};
    tbl[2]  = '{0,0, 1,5,1,  0,0,0,0,0};
    tbl[3]  = '{0,0, 0,0,0,  1,3,0,0,1};
    tbl[4]  = '{0,0, 1,5,1,  0,0,0,0,0};
    tbl[5]  = '{0,0, 0,0,0,  1,3,0,0,1};
    tbl[6]  = '{1,5, 0,0,0,  0,0,1,1,0};
    tbl[7]  = '{0,0, 1,2,0,  0,0,0,0,0};
    tbl[8]  = '{0,0, 0,0,0,  1,0,0,0,1};
    tbl[9]  = '{0,0, 1,2,0,  0,0,0,0,0};
    tbl[10] = '{0,0, 0,0,0,  1,0,0,0,1};
    tbl[11] = '{1,2, 0,0,0,  0,0,0,1,0};

    for (int i = 0; i < NENT; i++) begin ram[i] = 2'b11; mram[i] = 3; end
    lookup_valid = 0; lookup_idx = '0; upd_valid = 0; upd_idx = '0; upd_taken = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Clear sweep with updates offered throughout; none may be queued.
    for (int i = 0; i < NENT; i++) step(1'b1, 3, 1'b1, i, 1'b1);
    chk("init_done_after_sweep", int'(init_done), 1);
    chk("cnt_after_sweep", int'(fifo_count), 0);
    check_ram("init");

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].lv, tbl[i].li, tbl[i].uv, tbl[i].ui, tbl[i].ut);
      chk($sformatf("tbl%0d_we", i), s_we, tbl[i].e_we);
      if (tbl[i].e_we != 0) chk($sformatf("tbl%0d_wd", i), s_wd, tbl[i].e_wd);
      chk($sformatf("tbl%0d_bp", i), s_bp, tbl[i].e_bp);
      chk($sformatf("tbl%0d_bpv", i), s_bpv, tbl[i].e_bpv);
      chk($sformatf("tbl%0d_cnt", i), s_cnt, tbl[i].e_cnt);
    end

    // Starvation: one update behind continuous lookups.
    step(1'b1, 3, 1'b1, 6, 1'b1);
    for (int i = 0; i < SMAX; i++) begin
      step(1'b1, 3, 1'b0, 0, 1'b0);
      chk($sformatf("starve_lookup%0d", i), s_bpv, 1);
    end
    step(1'b1, 3, 1'b0, 0, 1'b0);
    chk("starve_force_bpv", s_bpv, 0);
    chk("starve_force_we", s_we, 1);
    chk("starve_force_bp", s_bp, 0);
    step(1'b1, 3, 1'b0, 0, 1'b0);
    chk("starve_after_bpv", s_bpv, 1);

    // Full FIFO with a push on the forced-drain cycle.
    step(1'b1, 0, 1'b1, 0, 1'b1);
    step(1'b1, 0, 1'b1, 1, 1'b1);
    step(1'b1, 0, 1'b1, 4, 1'b0);
    step(1'b1, 0, 1'b1, 7, 1'b1);
    step(1'b1, 0, 1'b1, 3, 1'b1);
    chk("full_cnt_before", s_cnt, 4);
    chk("full_forced_we", s_we, 1);
    chk("full_forced_bpv", s_bpv, 0);
    chk("full_cnt_after", int'(fifo_count), 4);
    for (int i = 0; i < 50; i++) step(1'b1, 0, 1'b0, 0, 1'b0);
    chk("full_drained", int'(fifo_count), 0);
    check_ram("full");

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, NENT - 1),
           $urandom_range(0, 2) == 0, $urandom_range(0, NENT - 1), $urandom_range(0, 1) == 1);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b0, 0, 1'b0);
    check_ram("rand");

    // Reset while updates are queued behind lookups.
    step(1'b1, 0, 1'b1, 1, 1'b1);
    step(1'b1, 0, 1'b1, 2, 1'b0);
    step(1'b1, 0, 1'b1, 3, 1'b1);
    chk("pre_reset_cnt", int'(fifo_count), 3);
    lookup_valid = 0; upd_valid = 0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst1");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NENT; i++) step(1'b0, 0, 1'b1, 5, 1'b0);
    chk("reinit_done", int'(init_done), 1);
    chk("reinit_cnt", int'(fifo_count), 0);
    step(1'b1, 2, 1'b0, 0, 1'b0);
    check_ram("reinit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
